seg_i2c_sequencer: RTL
======================

// Module: seg_i2c_sequencer
// PURPOSE
//  Transaction scheduler that drives the byte-level I2C master feeding the segment-display driver (seg_scl/seg_sda).
//  Builds each display update as START, device address, register pointer, NUM_DIGITS data bytes, STOP.
//  Launches on an update request or a periodic refresh tick; handles ACK/NACK and reports status upstream.
// PARAMETERS
//  NUM_DIGITS      4        digit bytes per transaction (1..8)
//  DEV_ADDR        7'h38    7-bit slave address; address byte = {DEV_ADDR,1'b0}
//  REG_ADDR        8'h00    first display register written
//  REFRESH_CYCLES  250000   clk_i cycles between automatic refreshes (20 ms at 12.5 MHz); 0 disables
//  MAX_RETRY       3        NACK retries per transaction (SEG_SEQ_RETRY_EN only)
// PORTS
//  clk_i        in   1               system clock
//  sync_reset_i in   1               synchronous reset, active-high
//  digits_i     in   8*NUM_DIGITS    segment patterns; byte 0 = digit 0, sent first
//  update_req_i in   1               1-cycle request for an immediate update
//  busy_o       out  1               transaction in progress
//  done_o       out  1               1-cycle pulse: transaction finished with all ACKs
//  err_o        out  1               1-cycle pulse: transaction aborted on NACK
//  cmd_valid_o  out  1               command to I2C master valid
//  cmd_ready_i  in   1               I2C master accepts command
//  cmd_o        out  2               2'b00 START, 2'b01 WRITE, 2'b10 STOP
//  cmd_data_o   out  8               byte for WRITE; 8'h00 otherwise
//  rsp_valid_i  in   1               I2C master completed the accepted command (1 cycle)
//  rsp_ack_i    in   1               with rsp_valid_i on WRITE: 1 = slave ACK, 0 = NACK
// BEHAVIOUR
//  Reset: all outputs 0; FSM=IDLE; refresh counter=0; pending=0; byte index=0; retry count=0.
//  Handshake: command transfers on cycle cmd_valid_o&&cmd_ready_i; cmd_o/cmd_data_o held stable while valid&&!ready;
//   cmd_valid_o drops next cycle; FSM waits for rsp_valid_i before next command. Max one command outstanding.
//  FSM: IDLE -> START -> ADDR -> REG -> DATA(idx 0..NUM_DIGITS-1) -> STOP -> IDLE.
//   Each state = issue command, then wait rsp_valid_i. rsp_ack_i ignored for START/STOP.
//   NACK in ADDR/REG/DATA -> STOP (bus always released) -> error handling below.
//  Launch: in IDLE with pending=1 -> snapshot digits_i into internal register, busy_o=1 next cycle,
//   cmd_valid_o with START on the cycle after that. Data bytes come from the snapshot only.
//  pending set by update_req_i or refresh tick; cleared on launch. Request during busy_o sets pending ->
//   exactly one new transaction after the current one; multiple requests during busy coalesce.
//  Refresh counter: free-runs 0..REFRESH_CYCLES-1, tick on wrap; counts during transactions.
//  Tick and update_req_i in same cycle -> single pending.
//  Completion: on STOP rsp_valid_i -> IDLE, busy_o=0, done_o or err_o pulses same cycle busy_o falls.
//  rsp_valid_i while no command outstanding: ignored. Reset mid-transaction: immediate IDLE, no STOP
//   issued (I2C master is reset by the same sync_reset_i).
//  Byte count per transaction: 2+NUM_DIGITS WRITEs, 1 START, 1 STOP.
// CONFIGURATION
//  SEG_SEQ_RETRY_EN defined: after STOP following a NACK, if retry count < MAX_RETRY, increment it and
//   restart from START with same snapshot (busy_o stays 1, no err_o); err_o only when retries exhausted.
//   Retry count cleared at each launch.
//  Not defined: any NACK -> STOP -> err_o, IDLE; no retry logic or counter synthesised.
// TESTING
//  Reset, then update_req_i with digits_i=32'h3F065B4F, ready/ack always 1 -> commands START, WRITE 70, 00,
//   3F,06,5B,4F, STOP in order; one done_o; busy_o 0 afterwards.
//  Hold cmd_ready_i=0 for 5 cycles on each command -> cmd_o/cmd_data_o stable, no command dropped/duplicated.
//  Change digits_i to 32'hFFFFFFFF mid-transaction -> remaining data bytes still from 32'h3F065B4F snapshot.
//  Three update_req_i pulses during busy -> exactly one extra transaction follows.
//  NACK on address byte -> STOP issued next; without macro err_o pulse; with SEG_SEQ_RETRY_EN and persistent NACK
//   -> 4 START/STOP attempts then err_o; NACK only on first attempt -> done_o, no err_o.
//  REFRESH_CYCLES=1000, no requests -> START every 1000 cycles; sync_reset_i mid-DATA -> outputs 0 next cycle.

Source files
------------

// File: rtl/seg_i2c_sequencer.sv
// seg_i2c_sequencer: schedules START / address / register / digit bytes / STOP
// transactions for the segment-display I2C master. SEG_SEQ_RETRY_EN adds NACK retries.
module seg_i2c_sequencer #(
    parameter int         NUM_DIGITS     = 4,
    parameter logic [6:0] DEV_ADDR       = 7'h38,
    parameter logic [7:0] REG_ADDR       = 8'h00,
    parameter int         REFRESH_CYCLES = 250000,
    parameter int         MAX_RETRY      = 3
) (
    input  logic                    clk_i,
    input  logic                    sync_reset_i,
    input  logic [8*NUM_DIGITS-1:0] digits_i,
    input  logic                    update_req_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    err_o,
    output logic                    cmd_valid_o,
    input  logic                    cmd_ready_i,
    output logic [1:0]              cmd_o,
    output logic [7:0]              cmd_data_o,
    input  logic                    rsp_valid_i,
    input  logic                    rsp_ack_i
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] START = 3'd1;
    localparam logic [2:0] ADDR  = 3'd2;
    localparam logic [2:0] REG   = 3'd3;
    localparam logic [2:0] DATA  = 3'd4;
    localparam logic [2:0] STOP  = 3'd5;

    localparam logic [1:0] CMD_START = 2'b00;
    localparam logic [1:0] CMD_WRITE = 2'b01;
    localparam logic [1:0] CMD_STOP  = 2'b10;

    localparam int IW   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CW   = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam int LAST = (REFRESH_CYCLES > 0) ? REFRESH_CYCLES - 1 : 0;

    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

    logic [2:0]                 state;
    logic [NUM_DIGITS-1:0][7:0] snap;
    logic [IW-1:0]              idx;
    logic                       pending;
    logic                       outstanding;
    logic                       nack;
    logic [CW-1:0]              refresh_cnt;
    logic                       tick;
    logic                       launch;
    logic                       rsp_take;
    logic                       retry;
    logic [1:0]                 next_cmd;
    logic [7:0]                 next_data;

    assign tick     = (REFRESH_CYCLES > 0) && (refresh_cnt == CW'(LAST));
    assign launch   = (state == IDLE) && pending;
    assign rsp_take = outstanding && rsp_valid_i;

    always_ff @(posedge clk_i) begin
        if (sync_reset_i || tick) begin
            refresh_cnt <= '0;
        end else if (REFRESH_CYCLES > 0) begin
            refresh_cnt <= refresh_cnt + 1'b1;
        end
    end

    // A request landing in the launch cycle is kept so it is not lost.
    always_ff @(posedge clk_i) begin
        if (sync_reset_i) begin
            pending <= 1'b0;
        end else begin
            pending <= (pending && !launch) || update_req_i || tick;
        end
    end

`ifdef SEG_SEQ_RETRY_EN
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    logic [RW-1:0] retry_cnt;

    assign retry = nack && (retry_cnt < RW'(MAX_RETRY));

    always_ff @(posedge clk_i) begin
        if (sync_reset_i || launch) begin
            retry_cnt <= '0;
        end else if (rsp_take && (state == STOP) && retry) begin
            retry_cnt <= retry_cnt + 1'b1;
        end
    end
`else
    assign retry = 1'b0;
`endif

    always_comb begin
        next_cmd  = CMD_WRITE;
        next_data = 8'h00;
        case (state)
            START:   next_cmd  = CMD_START;
            ADDR:    next_data = {DEV_ADDR, 1'b0};
            REG:     next_data = REG_ADDR;
            DATA:    next_data = snap[idx];
            STOP:    next_cmd  = CMD_STOP;
            default: next_cmd  = CMD_WRITE;
        endcase
    end

    // Per state: issue command, hold until accepted, then wait for its response.
    always_ff @(posedge clk_i) begin
        if (sync_reset_i) begin
            state       <= IDLE;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            err_o       <= 1'b0;
            cmd_valid_o <= 1'b0;
            cmd_o       <= CMD_START;
            cmd_data_o  <= 8'h00;
            outstanding <= 1'b0;
            nack        <= 1'b0;
            idx         <= '0;
            snap        <= '0;
        end else begin
            done_o <= 1'b0;
            err_o  <= 1'b0;
            if (launch) begin
                snap   <= digits_i;
                busy_o <= 1'b1;
                state  <= START;
                idx    <= '0;
                nack   <= 1'b0;
            end else if (state != IDLE) begin
                if (!cmd_valid_o && !outstanding) begin
                    cmd_valid_o <= 1'b1;
                    cmd_o       <= next_cmd;
                    cmd_data_o  <= next_data;
                end else if (cmd_valid_o && cmd_ready_i) begin
                    cmd_valid_o <= 1'b0;
                    cmd_o       <= CMD_START;
                    cmd_data_o  <= 8'h00;
                    outstanding <= 1'b1;
                end else if (rsp_take) begin
                    outstanding <= 1'b0;
                    case (state)
                        START: state <= ADDR;
                        ADDR: begin
                            nack  <= !rsp_ack_i;
                            state <= rsp_ack_i ? REG : STOP;
                        end
                        REG: begin
                            nack  <= !rsp_ack_i;
                            state <= rsp_ack_i ? DATA : STOP;
                        end
                        DATA: begin
                            nack <= !rsp_ack_i;
                            idx  <= idx + 1'b1;
                            if (!rsp_ack_i || idx == IDX_LAST) begin
                                state <= STOP;
                            end
                        end
                        STOP: begin
                            if (retry) begin
                                state <= START;
                                idx   <= '0;
                                nack  <= 1'b0;
                            end else begin
                                state  <= IDLE;
                                busy_o <= 1'b0;
                                done_o <= !nack;
                                err_o  <= nack;
                                nack   <= 1'b0;
                            end
                        end
                        default: state <= IDLE;
                    endcase
                end
            end
        end
    end

endmodule
